// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of a 5-stage RV32I pipeline plus the ID/EXE register.
//
// Reads the 32x32 register file (with write-back bypass), builds the sign-extended
// immediate and the control word, computes the branch/JAL and JALR targets, and
// registers everything into ID/EXE. A hazard-unit select squashes control to a bubble.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   rs1/rs2/rd_IF_ID                   register addresses from IF/ID
//   instruction_IF_ID                  raw instruction (immediate source, bit30 = funct7[5])
//   OPCODE_IF_ID, FUNCT3_IF_ID         decode fields
//   pc_IF_ID                           15-bit byte PC
//   control_MUX_select_HZRD            1 = insert bubble
//   RegWrite_WB, write_reg_WB, write_data_WB   register file write-back
//   *_ID_EXE                           registered operands, immediate, control, targets,
//                                      pc and register-address pass-through
module id_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_IF_ID,
    input  logic [4:0]  rs2_IF_ID,
    input  logic [4:0]  rd_IF_ID,
    input  logic [31:0] instruction_IF_ID,
    input  logic [6:0]  OPCODE_IF_ID,
    input  logic [2:0]  FUNCT3_IF_ID,
    input  logic [14:0] pc_IF_ID,
    input  logic        control_MUX_select_HZRD,
    input  logic        RegWrite_WB,
    input  logic [4:0]  write_reg_WB,
    input  logic [31:0] write_data_WB,
    output logic [31:0] read_data1_ID_EXE,
    output logic [31:0] read_data2_ID_EXE,
    output logic [31:0] immediate_ID_EXE,
    output logic        JAL_ID_EXE,
    output logic        JALR_ID_EXE,
    output logic [3:0]  MemRead_ID_EXE,
    output logic [3:0]  MemWrite_ID_EXE,
    output logic [3:0]  ALUOp_ID_EXE,
    output logic [1:0]  MemtoReg_ID_EXE,
    output logic        ALUSrc_ID_EXE,
    output logic        RegWrite_ID_EXE,
    output logic        branch_ID_EXE,
    output logic [14:0] branch_address_ID_EXE,
    output logic [14:0] jalr_address_ID_EXE,
    output logic [14:0] pc_ID_EXE,
    output logic [4:0]  rs1_ID_EXE,
    output logic [4:0]  rs2_ID_EXE,
    output logic [4:0]  rd_ID_EXE
);

    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpAuipc  = 7'h17;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpJal    = 7'h6F;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;

    logic [31:0] rf_q [32];
    logic [31:0] rs1_data, rs2_data, op_a, imm;
    logic [14:0] jalr_sum;
    logic        bit30;

    logic       jal_c, jalr_c, alusrc_c, regwrite_c, branch_c;
    logic [3:0] memread_c, memwrite_c, aluop_c;
    logic [1:0] memtoreg_c;

    // Opcode bits come in on their own port; the low 7 instruction bits are not needed.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^instruction_IF_ID[6:0];

    assign bit30 = instruction_IF_ID[30];

    // Register file; x0 is never written so it always holds 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RegWrite_WB && write_reg_WB != 5'd0) begin
            rf_q[write_reg_WB] <= write_data_WB;
        end
    end

    // Reads with same-cycle write-back bypass; rsN != 0 implies write_reg_WB != 0 on a hit.
    always_comb begin
        rs1_data = '0;
        if (rs1_IF_ID != 5'd0) begin
            rs1_data = (RegWrite_WB && write_reg_WB == rs1_IF_ID) ? write_data_WB
                                                                   : rf_q[rs1_IF_ID];
        end
        rs2_data = '0;
        if (rs2_IF_ID != 5'd0) begin
            rs2_data = (RegWrite_WB && write_reg_WB == rs2_IF_ID) ? write_data_WB
                                                                   : rf_q[rs2_IF_ID];
        end
    end

    // LUI uses a zero A operand and AUIPC the PC, so EXE can always add A + imm.
    always_comb begin
        op_a = rs1_data;
        if (OPCODE_IF_ID == OpLui) begin
            op_a = '0;
        end else if (OPCODE_IF_ID == OpAuipc) begin
            op_a = {17'd0, pc_IF_ID};
        end
    end

    always_comb begin
        imm = '0;
        case (OPCODE_IF_ID)
            OpLoad, OpImm, OpJalr:
                imm = {{20{instruction_IF_ID[31]}}, instruction_IF_ID[31:20]};
            OpStore:
                imm = {{20{instruction_IF_ID[31]}}, instruction_IF_ID[31:25],
                       instruction_IF_ID[11:7]};
            OpBranch:
                imm = {{19{instruction_IF_ID[31]}}, instruction_IF_ID[31], instruction_IF_ID[7],
                       instruction_IF_ID[30:25], instruction_IF_ID[11:8], 1'b0};
            OpLui, OpAuipc:
                imm = {instruction_IF_ID[31:12], 12'd0};
            OpJal:
                imm = {{11{instruction_IF_ID[31]}}, instruction_IF_ID[31],
                       instruction_IF_ID[19:12], instruction_IF_ID[20],
                       instruction_IF_ID[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign jalr_sum = rs1_data[14:0] + imm[14:0];

    always_comb begin
        jal_c      = 1'b0;
        jalr_c     = 1'b0;
        memread_c  = '0;
        memwrite_c = '0;
        aluop_c    = AluAdd;
        memtoreg_c = 2'b00;
        alusrc_c   = 1'b0;
        regwrite_c = 1'b0;
        branch_c   = 1'b0;
        case (OPCODE_IF_ID)
            OpReg, OpImm: begin
                regwrite_c = 1'b1;
                alusrc_c   = (OPCODE_IF_ID == OpImm);
                case (FUNCT3_IF_ID)
                    // funct7[5] means SUB only for register-register; ADDI is always ADD.
                    3'b000:  aluop_c = (bit30 && OPCODE_IF_ID == OpReg) ? AluSub : AluAdd;
                    3'b001:  aluop_c = AluSll;
                    3'b010:  aluop_c = AluSlt;
                    3'b011:  aluop_c = AluSltu;
                    3'b100:  aluop_c = AluXor;
                    3'b101:  aluop_c = bit30 ? AluSra : AluSrl;
                    3'b110:  aluop_c = AluOr;
                    default: aluop_c = AluAnd;
                endcase
            end
            OpLoad: begin
                memread_c  = {1'b1, FUNCT3_IF_ID};
                memtoreg_c = 2'b01;
                regwrite_c = 1'b1;
                alusrc_c   = 1'b1;
            end
            OpStore: begin
                memwrite_c = {1'b1, FUNCT3_IF_ID};
                alusrc_c   = 1'b1;
            end
            OpBranch: begin
                branch_c = 1'b1;
                case (FUNCT3_IF_ID)
                    3'b000:  aluop_c = 4'd10;
                    3'b001:  aluop_c = 4'd11;
                    3'b100:  aluop_c = 4'd12;
                    3'b101:  aluop_c = 4'd13;
                    3'b110:  aluop_c = 4'd14;
                    3'b111:  aluop_c = 4'd15;
                    default: aluop_c = AluAdd;  // undefined branch funct3
                endcase
            end
            OpLui, OpAuipc: begin
                alusrc_c   = 1'b1;
                regwrite_c = 1'b1;
            end
            OpJal: begin
                jal_c      = 1'b1;
                regwrite_c = 1'b1;
                memtoreg_c = 2'b10;
            end
            OpJalr: begin
                jalr_c     = 1'b1;
                regwrite_c = 1'b1;
                memtoreg_c = 2'b10;
                alusrc_c   = 1'b1;
            end
            default: ;
        endcase
    end

    // ID/EXE register. A bubble clears control only; data and addresses still advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data1_ID_EXE     <= '0;
            read_data2_ID_EXE     <= '0;
            immediate_ID_EXE      <= '0;
            JAL_ID_EXE            <= 1'b0;
            JALR_ID_EXE           <= 1'b0;
            MemRead_ID_EXE        <= '0;
            MemWrite_ID_EXE       <= '0;
            ALUOp_ID_EXE          <= '0;
            MemtoReg_ID_EXE       <= '0;
            ALUSrc_ID_EXE         <= 1'b0;
            RegWrite_ID_EXE       <= 1'b0;
            branch_ID_EXE         <= 1'b0;
            branch_address_ID_EXE <= '0;
            jalr_address_ID_EXE   <= '0;
            pc_ID_EXE             <= '0;
            rs1_ID_EXE            <= '0;
            rs2_ID_EXE            <= '0;
            rd_ID_EXE             <= '0;
        end else begin
            read_data1_ID_EXE     <= op_a;
            read_data2_ID_EXE     <= rs2_data;
            immediate_ID_EXE      <= imm;
            branch_address_ID_EXE <= pc_IF_ID + imm[14:0];
            jalr_address_ID_EXE   <= {jalr_sum[14:1], 1'b0};
            pc_ID_EXE             <= pc_IF_ID;
            rs1_ID_EXE            <= rs1_IF_ID;
            rs2_ID_EXE            <= rs2_IF_ID;
            rd_ID_EXE             <= rd_IF_ID;
            if (control_MUX_select_HZRD) begin
                JAL_ID_EXE      <= 1'b0;
                JALR_ID_EXE     <= 1'b0;
                MemRead_ID_EXE  <= '0;
                MemWrite_ID_EXE <= '0;
                ALUOp_ID_EXE    <= '0;
                MemtoReg_ID_EXE <= '0;
                ALUSrc_ID_EXE   <= 1'b0;
                RegWrite_ID_EXE <= 1'b0;
                branch_ID_EXE   <= 1'b0;
            end else begin
                JAL_ID_EXE      <= jal_c;
                JALR_ID_EXE     <= jalr_c;
                MemRead_ID_EXE  <= memread_c;
                MemWrite_ID_EXE <= memwrite_c;
                ALUOp_ID_EXE    <= aluop_c;
                MemtoReg_ID_EXE <= memtoreg_c;
                ALUSrc_ID_EXE   <= alusrc_c;
                RegWrite_ID_EXE <= regwrite_c;
                branch_ID_EXE   <= branch_c;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage. Each driven decode pushes its expected
// ID/EXE contents (from a small reference model with its own register file) onto a
// scoreboard queue; the checker pops one entry after every rising edge.
module tb_id_stage;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic        jal, jalr, alusrc, regwrite, branch;
        logic [3:0]  memread, memwrite, aluop;
        logic [1:0]  memtoreg;
        logic [14:0] baddr, jaddr, pc;
        logic [4:0]  rs1, rs2, rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1_IF_ID, rs2_IF_ID, rd_IF_ID;
    logic [31:0] instruction_IF_ID;
    logic [6:0]  OPCODE_IF_ID;
    logic [2:0]  FUNCT3_IF_ID;
    logic [14:0] pc_IF_ID;
    logic        control_MUX_select_HZRD;
    logic        RegWrite_WB;
    logic [4:0]  write_reg_WB;
    logic [31:0] write_data_WB;
    logic [31:0] read_data1_ID_EXE, read_data2_ID_EXE, immediate_ID_EXE;
    logic        JAL_ID_EXE, JALR_ID_EXE, ALUSrc_ID_EXE, RegWrite_ID_EXE, branch_ID_EXE;
    logic [3:0]  MemRead_ID_EXE, MemWrite_ID_EXE, ALUOp_ID_EXE;
    logic [1:0]  MemtoReg_ID_EXE;
    logic [14:0] branch_address_ID_EXE, jalr_address_ID_EXE, pc_ID_EXE;
    logic [4:0]  rs1_ID_EXE, rs2_ID_EXE, rd_ID_EXE;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    id_stage dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .rs1_IF_ID              (rs1_IF_ID),
        .rs2_IF_ID              (rs2_IF_ID),
        .rd_IF_ID               (rd_IF_ID),
        .instruction_IF_ID      (instruction_IF_ID),
        .OPCODE_IF_ID           (OPCODE_IF_ID),
        .FUNCT3_IF_ID           (FUNCT3_IF_ID),
        .pc_IF_ID               (pc_IF_ID),
        .control_MUX_select_HZRD(control_MUX_select_HZRD),
        .RegWrite_WB            (RegWrite_WB),
        .write_reg_WB           (write_reg_WB),
        .write_data_WB          (write_data_WB),
        .read_data1_ID_EXE      (read_data1_ID_EXE),
        .read_data2_ID_EXE      (read_data2_ID_EXE),
        .immediate_ID_EXE       (immediate_ID_EXE),
        .JAL_ID_EXE             (JAL_ID_EXE),
        .JALR_ID_EXE            (JALR_ID_EXE),
        .MemRead_ID_EXE         (MemRead_ID_EXE),
        .MemWrite_ID_EXE        (MemWrite_ID_EXE),
        .ALUOp_ID_EXE           (ALUOp_ID_EXE),
        .MemtoReg_ID_EXE        (MemtoReg_ID_EXE),
        .ALUSrc_ID_EXE          (ALUSrc_ID_EXE),
        .RegWrite_ID_EXE        (RegWrite_ID_EXE),
        .branch_ID_EXE          (branch_ID_EXE),
        .branch_address_ID_EXE  (branch_address_ID_EXE),
        .jalr_address_ID_EXE    (jalr_address_ID_EXE),
        .pc_ID_EXE              (pc_ID_EXE),
        .rs1_ID_EXE             (rs1_ID_EXE),
        .rs2_ID_EXE             (rs2_ID_EXE),
        .rd_ID_EXE              (rd_ID_EXE)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite_WB && write_reg_WB == a) return write_data_WB;
        return mregs[a];
    endfunction

    // Reference decode from the current bench inputs and the bench's register model.
    function automatic exp_t model();
        exp_t e;
        logic [31:0] i = instruction_IF_ID;
        logic [31:0] r1 = model_read(rs1_IF_ID);
        logic [31:0] sum;
        logic [3:0]  alu_tab [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        logic [3:0]  br_tab [8]  = '{4'd10, 4'd11, 4'd0, 4'd0, 4'd12, 4'd13, 4'd14, 4'd15};
        e = '{rd1: r1, rd2: model_read(rs2_IF_ID), imm: 32'd0, jal: 1'b0, jalr: 1'b0,
              alusrc: 1'b0, regwrite: 1'b0, branch: 1'b0, memread: 4'd0, memwrite: 4'd0,
              aluop: 4'd0, memtoreg: 2'd0, baddr: 15'd0, jaddr: 15'd0, pc: pc_IF_ID,
              rs1: rs1_IF_ID, rs2: rs2_IF_ID, rd: rd_IF_ID};
        case (OPCODE_IF_ID)
            7'h03, 7'h13, 7'h67: e.imm = 32'($signed(i[31:20]));
            7'h23: e.imm = 32'($signed({i[31:25], i[11:7]}));
            7'h63: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'h37, 7'h17: e.imm = i & 32'hFFFF_F000;
            7'h6F: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: e.imm = 32'd0;
        endcase
        case (OPCODE_IF_ID)
            7'h33: begin
                e.regwrite = 1'b1;
                e.aluop = alu_tab[FUNCT3_IF_ID];
                if (i[30] && FUNCT3_IF_ID == 3'd0) e.aluop = 4'd1;
                if (i[30] && FUNCT3_IF_ID == 3'd5) e.aluop = 4'd7;
            end
            7'h13: begin
                e.regwrite = 1'b1; e.alusrc = 1'b1;
                e.aluop = alu_tab[FUNCT3_IF_ID];
                if (i[30] && FUNCT3_IF_ID == 3'd5) e.aluop = 4'd7;
            end
            7'h03: begin
                e.memread = {1'b1, FUNCT3_IF_ID}; e.memtoreg = 2'b01;
                e.regwrite = 1'b1; e.alusrc = 1'b1;
            end
            7'h23: begin e.memwrite = {1'b1, FUNCT3_IF_ID}; e.alusrc = 1'b1; end
            7'h63: begin e.branch = 1'b1; e.aluop = br_tab[FUNCT3_IF_ID]; end
            7'h37: begin e.rd1 = 32'd0; e.alusrc = 1'b1; e.regwrite = 1'b1; end
            7'h17: begin e.rd1 = {17'd0, pc_IF_ID}; e.alusrc = 1'b1; e.regwrite = 1'b1; end
            7'h6F: begin e.jal = 1'b1; e.regwrite = 1'b1; e.memtoreg = 2'b10; end
            7'h67: begin
                e.jalr = 1'b1; e.regwrite = 1'b1; e.memtoreg = 2'b10; e.alusrc = 1'b1;
            end
            default: ;
        endcase
        if (control_MUX_select_HZRD) begin
            e.jal = 0; e.jalr = 0; e.memread = 0; e.memwrite = 0; e.aluop = 0;
            e.memtoreg = 0; e.alusrc = 0; e.regwrite = 0; e.branch = 0;
        end
        e.baddr = 15'((32'(pc_IF_ID) + e.imm) % 32'h8000);
        sum = r1 + e.imm;
        e.jaddr = sum[14:0] & 15'h7FFE;
        return e;
    endfunction

    // Drive one decode plus one write-back on the falling edge and push its expectation.
    task automatic drive(input logic [31:0] ins, input logic [14:0] pc, input logic hz,
                         input logic wb_en, input logic [4:0] wb_reg, input logic [31:0] wb_dat);
        @(negedge clk);
        instruction_IF_ID       = ins;
        OPCODE_IF_ID            = ins[6:0];
        FUNCT3_IF_ID            = ins[14:12];
        rs1_IF_ID               = ins[19:15];
        rs2_IF_ID               = ins[24:20];
        rd_IF_ID                = ins[11:7];
        pc_IF_ID                = pc;
        control_MUX_select_HZRD = hz;
        RegWrite_WB             = wb_en;
        write_reg_WB            = wb_reg;
        write_data_WB           = wb_dat;
        sb.push_back(model());
        if (wb_en && wb_reg != 5'd0) mregs[wb_reg] = wb_dat;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("rd1", read_data1_ID_EXE, e.rd1);
            check_eq("rd2", read_data2_ID_EXE, e.rd2);
            check_eq("imm", immediate_ID_EXE, e.imm);
            check_eq("jal", 32'(JAL_ID_EXE), 32'(e.jal));
            check_eq("jalr", 32'(JALR_ID_EXE), 32'(e.jalr));
            check_eq("memread", 32'(MemRead_ID_EXE), 32'(e.memread));
            check_eq("memwrite", 32'(MemWrite_ID_EXE), 32'(e.memwrite));
            check_eq("aluop", 32'(ALUOp_ID_EXE), 32'(e.aluop));
            check_eq("memtoreg", 32'(MemtoReg_ID_EXE), 32'(e.memtoreg));
            check_eq("alusrc", 32'(ALUSrc_ID_EXE), 32'(e.alusrc));
            check_eq("regwrite", 32'(RegWrite_ID_EXE), 32'(e.regwrite));
            check_eq("branch", 32'(branch_ID_EXE), 32'(e.branch));
            check_eq("baddr", 32'(branch_address_ID_EXE), 32'(e.baddr));
            check_eq("jaddr", 32'(jalr_address_ID_EXE), 32'(e.jaddr));
            check_eq("pc", 32'(pc_ID_EXE), 32'(e.pc));
            check_eq("rs1", 32'(rs1_ID_EXE), 32'(e.rs1));
            check_eq("rs2", 32'(rs2_ID_EXE), 32'(e.rs2));
            check_eq("rd", 32'(rd_ID_EXE), 32'(e.rd));
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd1"}, read_data1_ID_EXE, 32'd0);
        check_eq({tag, "_imm"}, immediate_ID_EXE, 32'd0);
        check_eq({tag, "_ctl"}, {JAL_ID_EXE, JALR_ID_EXE, MemRead_ID_EXE, MemWrite_ID_EXE,
                 ALUOp_ID_EXE, MemtoReg_ID_EXE, ALUSrc_ID_EXE, RegWrite_ID_EXE,
                 branch_ID_EXE}, 32'd0);
        check_eq({tag, "_pc"}, 32'(pc_ID_EXE), 32'd0);
    endtask

    initial begin
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                                  7'h67, 7'h21};
        logic [31:0] ins;
        logic [4:0]  wr;
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        reset_n = 1'b0;
        instruction_IF_ID = 32'h00d30293; OPCODE_IF_ID = 7'h13; FUNCT3_IF_ID = 3'd0;
        rs1_IF_ID = 5'd6; rs2_IF_ID = 5'd13; rd_IF_ID = 5'd5; pc_IF_ID = 15'h0100;
        control_MUX_select_HZRD = 1'b0; RegWrite_WB = 1'b0; write_reg_WB = '0;
        write_data_WB = '0;
        repeat (2) @(posedge clk);
        #3;
        check_all_zero("reset");
        @(negedge clk) reset_n = 1'b1;

        // addi x5, x6, 13
        drive(32'h00d30293, 15'h0100, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("addi_imm", immediate_ID_EXE, 32'h0000_000D);
        check_eq("addi_x6", read_data1_ID_EXE, 32'd0);
        check_eq("addi_ctl", {ALUSrc_ID_EXE, RegWrite_ID_EXE, ALUOp_ID_EXE}, 32'b1_1_0000);

        // Bypass: write x5=55 while reading rs1=5 (addi x1, x5, 0).
        drive(32'h00028093, 15'h0104, 1'b0, 1'b1, 5'd5, 32'd55);
        after_edge();
        check_eq("bypass_x5", read_data1_ID_EXE, 32'd55);
        drive(32'h00028093, 15'h0108, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("later_x5", read_data1_ID_EXE, 32'd55);
        // Write to x0 and read it back the same cycle and the next.
        drive(32'h00000093, 15'h010C, 1'b0, 1'b1, 5'd0, 32'd123);
        drive(32'h00000093, 15'h0110, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("x0_zero", read_data1_ID_EXE, 32'd0);

        // Bubble, with write x2=69 then read rs2=2 (add x3, x1, x2).
        drive(32'h002081b3, 15'h0114, 1'b1, 1'b1, 5'd2, 32'd69);
        after_edge();
        check_eq("bubble_ctl", {JAL_ID_EXE, JALR_ID_EXE, MemRead_ID_EXE, MemWrite_ID_EXE,
                 ALUOp_ID_EXE, MemtoReg_ID_EXE, ALUSrc_ID_EXE, RegWrite_ID_EXE,
                 branch_ID_EXE}, 32'd0);
        drive(32'h002081b3, 15'h0118, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("x2_read", read_data2_ID_EXE, 32'd69);

        // sw with negative offset.
        drive(32'hf853ae23, 15'h011C, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("sw_imm", immediate_ID_EXE, 32'hFFFF_FF9C);
        check_eq("sw_ctl", {MemWrite_ID_EXE, ALUSrc_ID_EXE, RegWrite_ID_EXE}, 32'b1010_1_0);

        // Unknown opcode 33 (0x21).
        drive(32'hFFFFFFA1, 15'h0120, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("unk_ctl", {JAL_ID_EXE, JALR_ID_EXE, MemRead_ID_EXE, MemWrite_ID_EXE,
                 ALUOp_ID_EXE, MemtoReg_ID_EXE, ALUSrc_ID_EXE, RegWrite_ID_EXE,
                 branch_ID_EXE}, 32'd0);

        // beq x0, x0, +0x20 from pc 0x7FF0 wraps to 0x0010.
        drive(32'h02000063, 15'h7FF0, 1'b0, 1'b0, 5'd0, 32'd0);
        after_edge();
        check_eq("br_wrap", 32'(branch_address_ID_EXE), 32'h0010);
        check_eq("br_aluop", 32'(ALUOp_ID_EXE), 32'd10);

        // Random decodes with random write-backs, some aimed at the read ports.
        for (int n = 0; n < 60; n++) begin
            ins = {$urandom()} & 32'hFFFF_FF80;
            ins[6:0] = ops[$urandom_range(0, 9)];
            wr = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom());
            drive(ins, 15'($urandom()), ($urandom_range(0, 3) == 0), 1'($urandom()), wr,
                  $urandom());
        end

        // Asynchronous reset mid-run clears outputs and the register file.
        after_edge();
        #1;
        reset_n = 1'b0;
        RegWrite_WB = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        drive(32'h00028093, 15'h0200, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(32'h00000013, 15'h0204, 1'b0, 1'b0, 5'd0, 32'd0);

        for (int c = 0; c < 5 && sb.size() > 0; c++) after_edge();
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
